// File: rtl/imm_encode_stream_pkg.sv
// Shared definitions for the instruction-memory load-path immediate encoder.
// Also consumed by the core's immediate decode side (INSTR_W, IMM_* codes).
package imm_encode_stream_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned IMM_W     = 32;
  localparam int unsigned IMM_SRC_W = 2;

  localparam logic [IMM_SRC_W-1:0] IMM_I = 2'b00;
  localparam logic [IMM_SRC_W-1:0] IMM_S = 2'b01;
  localparam logic [IMM_SRC_W-1:0] IMM_B = 2'b10;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               err;
  } enc_word_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  addr;
    logic               err;
  } out_word_t;

  // True when bits [IMM_W-1:lsb] are all copies of the sign bit.
  function automatic logic upper_uniform(input logic [IMM_W-1:0] v, input int unsigned lsb);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < IMM_W; i++) begin
      if (i >= lsb && v[i] != v[IMM_W-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_encode_stream_if.sv
// Input and output stream channels of the immediate encoder.
interface imm_encode_stream_if import imm_encode_stream_pkg::*; ();

  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_W-1:0]   in_base;
  logic [IMM_W-1:0]     in_imm;
  logic [IMM_SRC_W-1:0] in_imm_src;

  logic                 out_valid;
  logic                 out_ready;
  logic [INSTR_W-1:0]   out_instr;
  logic [ADDR_W-1:0]    out_addr;
  logic                 out_err;

  modport master (
    output in_valid, in_base, in_imm, in_imm_src, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_base, in_imm, in_imm_src, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );

endinterface

// File: rtl/imm_encode_stream_field_pack.sv
// Combinational range check and scatter of an immediate into I/S/B fields.
module imm_field_pack
  import imm_encode_stream_pkg::*;
(
  input  logic [INSTR_W-1:0]   base,
  input  logic [IMM_W-1:0]     imm,
  input  logic [IMM_SRC_W-1:0] imm_src,
  output logic [INSTR_W-1:0]   instr,
  output logic                 err
);

  always_comb begin
    instr = base;
    err   = 1'b0;
    case (imm_src)
      IMM_I: begin
        err          = !upper_uniform(imm, 11);
        instr[31:20] = err ? 12'd0 : imm[11:0];
      end
      IMM_S: begin
        err          = !upper_uniform(imm, 11);
        instr[31:25] = err ? 7'd0 : imm[11:5];
        instr[11:7]  = err ? 5'd0 : imm[4:0];
      end
      IMM_B: begin
        // Branch offsets are halfword aligned; bit 0 has no encoding slot.
        err          = !upper_uniform(imm, 12) || imm[0];
        instr[31]    = err ? 1'b0 : imm[12];
        instr[7]     = err ? 1'b0 : imm[11];
        instr[30:25] = err ? 6'd0 : imm[10:5];
        instr[11:8]  = err ? 4'd0 : imm[4:1];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encode_stream.sv
// Two-stage streaming immediate encoder with running byte address and error count.
module imm_encode_stream
  import imm_encode_stream_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  imm_encode_stream_if.slave bus,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_init,
  output logic [CNT_W-1:0]  err_count
);

  logic              s1_valid;
  enc_word_t         s1_q;
  enc_word_t         enc_c;
  logic              s2_valid;
  out_word_t         s2_q;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] cap_addr_c;
  logic              s1_load_c;
  logic              s2_load_c;
  logic              out_fire_c;

  imm_field_pack u_pack (
    .base    (bus.in_base),
    .imm     (bus.in_imm),
    .imm_src (bus.in_imm_src),
    .instr   (enc_c.instr),
    .err     (enc_c.err)
  );

  assign s2_load_c    = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready = !s1_valid || s2_load_c;
  assign s1_load_c    = bus.in_valid && bus.in_ready;
  assign out_fire_c   = s2_valid && bus.out_ready;
  // A load coinciding with a capture redirects that very word.
  assign cap_addr_c   = addr_load ? addr_init : addr_cnt;

  // Stage 1: encoded word and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load_c) begin
      s1_valid <= 1'b1;
      s1_q     <= enc_c;
    end else if (s2_load_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output word with its address; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_load_c) begin
      s2_valid <= 1'b1;
      s2_q     <= '{instr: s1_q.instr, addr: cap_addr_c, err: s1_q.err};
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt <= '0;
    end else if (s2_load_c) begin
      addr_cnt <= cap_addr_c + ADDR_W'(4);
    end else if (addr_load) begin
      addr_cnt <= addr_init;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_fire_c && s2_q.err && !(&err_count)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_instr = s2_q.instr;
  assign bus.out_addr  = s2_q.addr;
  assign bus.out_err   = s2_q.err;

endmodule

// File: tb/tb_imm_encode_stream.sv
// Scoreboard bench for imm_encode_stream: directed words, queue-based output monitor.
module tb_imm_encode_stream;
  import imm_encode_stream_pkg::*;

  localparam int unsigned CNT_W = 16;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             addr_load = 1'b0;
  logic [31:0]      addr_init = '0;
  logic [CNT_W-1:0] err_count;

  imm_encode_stream_if bus ();

  imm_encode_stream #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .addr_load (addr_load),
    .addr_init (addr_init),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          exp_errs = 0;
  logic        stall_q = 1'b0;
  logic [31:0] held_instr, held_addr;
  logic        held_err;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every output transfer and checks stability under stall.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_errs = 0;
      stall_q  = 1'b0;
    end else begin
      if (stall_q) begin
        check32("stall_valid", 32'(bus.out_valid), 32'd1);
        check32("stall_instr", bus.out_instr, held_instr);
        check32("stall_addr", bus.out_addr, held_addr);
        check32("stall_err", 32'(bus.out_err), 32'(held_err));
      end
      if (bus.out_valid && bus.out_ready) begin
        check32("err_count_run", 32'(err_count), 32'(exp_errs));
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %h expected none", bus.out_instr);
        end else begin
          mon_e = sb.pop_front();
          check32("out_instr", bus.out_instr, mon_e.instr);
          check32("out_addr", bus.out_addr, mon_e.addr);
          check32("out_err", 32'(bus.out_err), 32'(mon_e.err));
          if (mon_e.err) exp_errs++;
        end
      end
      stall_q    = bus.out_valid && !bus.out_ready;
      held_instr = bus.out_instr;
      held_addr  = bus.out_addr;
      held_err   = bus.out_err;
    end
  end

  // Offer one word until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] base, input logic [31:0] imm, input logic [1:0] src,
                      input logic [31:0] eaddr, input logic [31:0] einstr, input logic eerr);
    logic acc;
    exp_t e;
    e.instr = einstr;
    e.addr  = eaddr;
    e.err   = eerr;
    sb.push_back(e);
    bus.in_valid   = 1'b1;
    bus.in_base    = base;
    bus.in_imm     = imm;
    bus.in_imm_src = src;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 for base %h", base);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    addr_load    = 1'b0;
    @(posedge clk);
    #1;
    check32("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check32("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check32("rst_err_count", 32'(err_count), 32'd0);
    check32("rst_out_addr", bus.out_addr, 32'd0);
    check32("rst_out_instr", bus.out_instr, 32'd0);
    check32("rst_out_err", 32'(bus.out_err), 32'd0);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (sb.size() != 0 && n < 100);
    #1;
    check32("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_base    = '0;
    bus.in_imm     = '0;
    bus.in_imm_src = '0;
    bus.out_ready  = 1'b1;

    // I-type with latency check
    do_reset();
    send(32'h0000_0093, 32'hFFFF_FFFF, IMM_I, 32'h0, 32'hFFF0_0093, 1'b0);
    check32("lat_valid_early", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check32("lat_valid", 32'(bus.out_valid), 32'd1);
    drain();
    check32("err_count_i", 32'(err_count), 32'd0);

    // S, B and the three error cases
    do_reset();
    send(32'h0020_A023, 32'h0000_0008, IMM_S, 32'h0, 32'h0020_A423, 1'b0);
    send(32'h0000_0063, 32'hFFFF_FFFC, IMM_B, 32'h4, 32'hFE00_0EE3, 1'b0);
    send(32'h0000_0093, 32'h0000_0800, IMM_I, 32'h8, 32'h0000_0093, 1'b1);
    send(32'h0000_0063, 32'h0000_0003, IMM_B, 32'hC, 32'h0000_0063, 1'b1);
    send(32'h1234_5677, 32'h0000_0005, 2'b11, 32'h10, 32'h1234_5677, 1'b1);
    drain();
    check32("err_count_3", 32'(err_count), 32'd3);

    // Backpressure: out_ready low for 3 cycles
    do_reset();
    bus.out_ready = 1'b0;
    fork
      begin
        send(32'h0000_0013, 32'd1, IMM_I, 32'h0, 32'h0010_0013, 1'b0);
        send(32'h0000_0013, 32'd2, IMM_I, 32'h4, 32'h0020_0013, 1'b0);
        send(32'h0000_0013, 32'd3, IMM_I, 32'h8, 32'h0030_0013, 1'b0);
        send(32'h0000_0013, 32'd4, IMM_I, 32'hC, 32'h0040_0013, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        check32("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Address load while idle
    addr_load = 1'b1;
    addr_init = 32'h0000_0100;
    @(posedge clk);
    #1;
    addr_load = 1'b0;
    send(32'h0000_0013, 32'h0000_07FF, IMM_I, 32'h100, 32'h7FF0_0013, 1'b0);
    send(32'h0000_0023, 32'hFFFF_F800, IMM_S, 32'h104, 32'h8000_0023, 1'b0);
    drain();

    // Address load coinciding with a stage-2 capture, then wrap
    send(32'h0000_0063, 32'h0000_0FFE, IMM_B, 32'hFFFF_FFFC, 32'h7E00_0FE3, 1'b0);
    addr_load = 1'b1;
    addr_init = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    addr_load = 1'b0;
    send(32'h0000_0013, 32'h0000_0000, IMM_I, 32'h0, 32'h0000_0013, 1'b0);
    drain();

    // Reset mid-stream with both stages full and a nonzero error count
    send(32'h0000_0013, 32'h0000_1000, IMM_I, 32'h4, 32'h0000_0013, 1'b1);
    drain();
    check32("err_count_pre", 32'(err_count), 32'd1);
    bus.out_ready = 1'b0;
    send(32'h0000_0013, 32'd5, IMM_I, 32'h8, 32'h0050_0013, 1'b0);
    send(32'h0000_0013, 32'd6, IMM_I, 32'hC, 32'h0060_0013, 1'b0);
    check32("full_in_ready", 32'(bus.in_ready), 32'd0);
    do_reset();
    bus.out_ready = 1'b1;
    send(32'h0000_0013, 32'd7, IMM_I, 32'h0, 32'h0070_0013, 1'b0);
    drain();
    check32("err_count_end", 32'(err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_encode_stream.md
# imm_encode_stream

Streaming instruction assembler for the pipeline's instruction-memory load path. It accepts a base instruction word (opcode, register and funct fields set, immediate bits don't-care), a 32-bit immediate value and an immediate-format select. It range-checks the immediate, scatters it into the I, S or B bit positions, and emits the finished word with a running instruction-memory byte address. It is the encoding counterpart of the core's immediate sign-extension decode: any legal word it emits decodes back to the original immediate.

## Interface
Parameters:
- CNT_W, 16, width of the saturating error counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input word offered
- in_ready  output  1  block can accept this cycle
- in_base  input  32  base instruction; immediate bit positions ignored
- in_imm  input  32  immediate value, two's complement
- in_imm_src  input  2  00 I-type, 01 S-type, 10 B-type, 11 illegal
- addr_load  input  1  load address counter from addr_init
- addr_init  input  32  new start byte address
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts
- out_instr  output  32  assembled instruction
- out_addr  output  32  byte address for out_instr
- out_err  output  1  immediate was out of range or format illegal
- err_count  output  CNT_W  saturating count of errored words emitted

## Operation
- Transfer happens on a channel when valid && ready at the rising edge.
- Non-immediate bits of out_instr are always copied from in_base.
- I-type: [31:20] = imm[11:0]. Legal iff imm[31:11] are all equal.
- S-type: [31:25] = imm[11:5], [11:7] = imm[4:0]. Legal iff imm[31:11] are all equal.
- B-type: [31] = imm[12], [7] = imm[11], [30:25] = imm[10:5], [11:8] = imm[4:1]. Legal iff imm[31:12] are all equal and imm[0] = 0.
- Illegal (out-of-range immediate or imm_src = 11):
  - out_err = 1.
  - All immediate bit positions of the selected format are 0. For 11, out_instr = in_base unchanged.
  - The word is still emitted and consumes an address.
- Address counter:
  - Holds the address given to the next word entering stage 2.
  - Increments by 4 per stage-2 capture, wrapping 0xFFFFFFFC -> 0.
  - If addr_load coincides with a capture, the captured word takes addr_init and the counter becomes addr_init + 4.
  - addr_load without a capture sets the counter to addr_init.
- err_count increments when an errored word transfers out, and saturates at all-ones.

## Timing
- Two register stages:
  - S1 holds the encoded word and error flag.
  - S2 holds the output word and address.
- Latency: 2 cycles from input transfer to out_valid, with out_ready high.
- Throughput: 1 word per cycle.
- S2 loads when S1 is valid and (!s2_valid || out_ready).
- S1 loads when in_valid and in_ready.
- in_ready = !s1_valid || s2 can load. This is combinational from out_ready; there is no combinational path from in_valid to out_valid.
- While out_valid && !out_ready, out_instr, out_addr and out_err hold stable.
- Ordering is preserved. No word is dropped or duplicated.
- Reset, including mid-stream:
  - Both stages are flushed; out_valid = 0 and in_ready = 1 in the cycle after rst.
  - out_instr = 0, out_addr = 0, out_err = 0, err_count = 0, address counter = 0.
  - In-flight words are discarded.

## Structure
- Shared package:
  - imm_src encoding constants (IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10).
  - The instruction-width constant, also used by the decode side.
- One natural sub-module: imm_field_pack. It is combinational and takes base, imm and imm_src to produce instr and err; stage S1 registers its outputs.
- The address counter, error counter and handshake logic live in the top.

## Test plan
- I-type: base 0x00000093, imm 0xFFFFFFFF, src 00 -> out_instr 0xFFF00093, out_err 0, out_addr 0x0, 2 cycles after accept.
- S-type: base 0x0020A023, imm 8, src 01 -> 0x0020A423. B-type: base 0x00000063, imm 0xFFFFFFFC, src 10 -> 0xFE000EE3. Addresses 0x0 then 0x4.
- Range errors:
  - I-type imm 2048 -> out_instr 0x00000093, out_err 1, err_count 1.
  - B-type imm 3 -> out_err 1, err_count 2.
  - src 11 -> in_base passed through, err_count 3.
- Backpressure: stream 4 words with out_ready held low for 3 cycles -> in_ready drops after 2 words are held; all 4 words emerge in order at addresses 0x0, 0x4, 0x8, 0xC with outputs stable while stalled.
- Address control:
  - addr_load with addr_init 0x100 while idle, then 2 words -> addresses 0x100 and 0x104.
  - addr_load with addr_init 0xFFFFFFFC coincident with a capture -> that word at 0xFFFFFFFC, next word at 0x0.
- Reset mid-stream: assert rst with both stages full -> next cycle out_valid 0, err_count 0. A following word gets out_addr 0x0.
